// File: rtl/d_alu_if.sv
// d_alu_if: operand/opcode/flag bundle between the dCPU control path and d_alu.
// The master drives operands, opcode and the flag-load strobe; the slave (ALU)
// returns the combinational result/flags and the registered flags.
interface d_alu_if;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       flags_load;
  logic [7:0] result;
  logic [3:0] flags;
  logic [3:0] flags_q;

  modport master (
    output a, b, op, flags_load,
    input  result, flags, flags_q
  );

  modport slave (
    input  a, b, op, flags_load,
    output result, flags, flags_q
  );
endinterface

// File: rtl/d_alu.sv
// d_alu: 8-bit accumulator ALU with combinational result/flags and a
// load-enabled flag register.
// Flag layout: [0] ZERO, [1] CARRY, [2] NEG, [3] OVF.
// Build option: D_ALU_EXT_OPS_EN enables opcodes 3..10 (AND/OR/XOR/NOT/SHL/
// SHR/INC/DEC); without it only PASS/ADD/SUB exist and every other opcode,
// flags included, behaves as PASS.
module d_alu (
  input  logic    clk,
  input  logic    rst,
  d_alu_if.slave  bus
);

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
`ifdef D_ALU_EXT_OPS_EN
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_INC  = 4'd9;
  localparam logic [3:0] OP_DEC  = 4'd10;
`endif

  logic [7:0] a, b;
  logic [8:0] sum9;
  logic [7:0] diff;
`ifdef D_ALU_EXT_OPS_EN
  logic [8:0] inc9;
  logic [7:0] dec8;
`endif

  logic [7:0] result;
  logic       carry;
  logic       ovf;
  logic [3:0] flags_d;
  logic [3:0] flags_q;

  assign a    = bus.a;
  assign b    = bus.b;
  assign sum9 = {1'b0, a} + {1'b0, b};
  assign diff = a - b;
`ifdef D_ALU_EXT_OPS_EN
  assign inc9 = {1'b0, a} + 9'd1;
  assign dec8 = a - 8'd1;
`endif

  // Opcode decode: result, carry and signed overflow; reserved codes fall to PASS.
  always_comb begin
    result = b;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (bus.op)
      OP_PASS: result = b;
      OP_ADD: begin
        result = sum9[7:0];
        carry  = sum9[8];
        ovf    = (a[7] == b[7]) && (sum9[7] != a[7]);
      end
      OP_SUB: begin
        // CARRY means acc > operand (unsigned), matching JMPC/JMPNC semantics.
        result = diff;
        carry  = (a > b);
        ovf    = (a[7] != b[7]) && (diff[7] != a[7]);
      end
`ifdef D_ALU_EXT_OPS_EN
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[6:0], 1'b0};
        carry  = a[7];
      end
      OP_SHR: begin
        result = {1'b0, a[7:1]};
        carry  = a[0];
      end
      OP_INC: begin
        result = inc9[7:0];
        carry  = inc9[8];
        ovf    = ~a[7] && inc9[7];
      end
      OP_DEC: begin
        // Same "acc > operand" convention as SUB, with the operand fixed at 1.
        result = dec8;
        carry  = (a > 8'd1);
        ovf    = a[7] && ~dec8[7];
      end
`endif
      default: result = b;
    endcase
  end

  assign flags_d = {ovf, result[7], carry, (result == 8'd0)};

  // Flag register: reset wins over load, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst)                 flags_q <= 4'b0000;
    else if (bus.flags_load) flags_q <= flags_d;
  end

  assign bus.result  = result;
  assign bus.flags   = flags_d;
  assign bus.flags_q = flags_q;

endmodule

// File: tb/tb_d_alu.sv
// tb_d_alu: directed vectors with hand-computed expectations pushed into a
// scoreboard queue; an independent monitor pops and compares each cycle.
module tb_d_alu;

`ifdef D_ALU_EXT_OPS_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic clk;
  logic rst;
  d_alu_if u_if ();

  d_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic [3:0] fl;
    logic [3:0] fq;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: combinational outputs settle after the drive at posedge+1, so
  // every pending expectation is checked on the following falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (u_if.result !== e.res) begin
        n_fail++;
        $display("FAIL %s result: got %h expected %h", e.name, u_if.result, e.res);
      end
      n_tests++;
      if (u_if.flags !== e.fl) begin
        n_fail++;
        $display("FAIL %s flags: got %b expected %b", e.name, u_if.flags, e.fl);
      end
      n_tests++;
      if (u_if.flags_q !== e.fq) begin
        n_fail++;
        $display("FAIL %s flags_q: got %b expected %b", e.name, u_if.flags_q, e.fq);
      end
    end
  end

  // One cycle of stimulus; fq is the register value expected this cycle,
  // i.e. the effect of the previous cycle's load/reset.
  task automatic vec(input string nm, input logic [7:0] a, input logic [7:0] b,
                     input logic [3:0] op, input logic ld, input logic r,
                     input logic [7:0] res, input logic [3:0] fl, input logic [3:0] fq);
    exp_t e;
    @(posedge clk);
    #1;
    u_if.a          = a;
    u_if.b          = b;
    u_if.op         = op;
    u_if.flags_load = ld;
    rst             = r;
    e.name = nm; e.res = res; e.fl = fl; e.fq = fq;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    u_if.a = 8'h00; u_if.b = 8'h00; u_if.op = 4'd0; u_if.flags_load = 1'b1;
    repeat (3) @(posedge clk);

    //   name        a      b      op  ld  rst  result                  flags                 flags_q
    vec("pass0",   8'h55, 8'h00, 4'd0, 1, 0, 8'h00,                    4'b0001,               4'b0000);
    vec("add_c",   8'hFF, 8'h01, 4'd1, 0, 0, 8'h00,                    4'b0011,               4'b0001);
    vec("add_v",   8'h7F, 8'h01, 4'd1, 1, 0, 8'h80,                    4'b1100,               4'b0001);
    vec("sub_gt",  8'hD0, 8'h10, 4'd2, 0, 0, 8'hC0,                    4'b0110,               4'b1100);
    vec("sub_eq",  8'hC0, 8'hC0, 4'd2, 0, 0, 8'h00,                    4'b0001,               4'b1100);
    vec("sub_lt",  8'h05, 8'h06, 4'd2, 0, 0, 8'hFF,                    4'b0100,               4'b1100);
    vec("shl",     8'h81, 8'h33, 4'd7, 0, 0, EXT ? 8'h02 : 8'h33,      EXT ? 4'b0010 : 4'b0000, 4'b1100);
    vec("shr",     8'h81, 8'h33, 4'd8, 0, 0, EXT ? 8'h40 : 8'h33,      EXT ? 4'b0010 : 4'b0000, 4'b1100);
    vec("not",     8'h81, 8'h33, 4'd6, 0, 0, EXT ? 8'h7E : 8'h33,      4'b0000,               4'b1100);
    vec("ld0011",  8'hFF, 8'h01, 4'd1, 1, 0, 8'h00,                    4'b0011,               4'b1100);
    vec("rst_ld",  8'h00, 8'h00, 4'd0, 1, 1, 8'h00,                    4'b0001,               4'b0011);
    vec("or_hold", 8'h01, 8'h02, 4'd4, 0, 0, EXT ? 8'h03 : 8'h02,      4'b0000,               4'b0000);
    vec("rsv13",   8'h00, 8'hA5, 4'd13,1, 0, 8'hA5,                    4'b0100,               4'b0000);
    vec("sub_v",   8'h80, 8'h01, 4'd2, 0, 0, 8'h7F,                    4'b1010,               4'b0100);
    vec("inc_c",   8'hFF, 8'h00, 4'd9, 0, 0, 8'h00,                    EXT ? 4'b0011 : 4'b0001, 4'b0100);
    vec("dec_v",   8'h80, 8'h10, 4'd10,0, 0, EXT ? 8'h7F : 8'h10,      EXT ? 4'b1010 : 4'b0000, 4'b0100);
    vec("dec_z",   8'h01, 8'h00, 4'd10,0, 0, 8'h00,                    4'b0001,               4'b0100);
    vec("inc_v",   8'h7F, 8'h80, 4'd9, 0, 0, 8'h80,                    EXT ? 4'b1100 : 4'b0100, 4'b0100);
    vec("xor",     8'hF0, 8'h0F, 4'd5, 0, 0, EXT ? 8'hFF : 8'h0F,      EXT ? 4'b0100 : 4'b0000, 4'b0100);
    vec("and",     8'hF0, 8'h0F, 4'd3, 0, 0, EXT ? 8'h00 : 8'h0F,      EXT ? 4'b0001 : 4'b0000, 4'b0100);
    vec("rsv15",   8'hC3, 8'h80, 4'd15,0, 0, 8'h80,                    4'b0100,               4'b0100);

    repeat (3) @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
